serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Parallel-to-serial frame transmitter directly upstream of the serial parity detector.
- Accepts a WIDTH-bit word through a ready/load handshake and emits it MSB-first, one bit per clk, on the serial line x.
- Optionally appends one parity bit, so the downstream parity detector sees a frame whose total parity is known.
- Qualifier outputs (x_valid, last) mark where frames start and end.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- PARITY_EN, 1, 1 appends a parity bit after the data bits; 0 sends data bits only.
- ODD, 0, 0 selects even parity (total ones in data plus parity is even); 1 selects odd parity.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  request to start a frame; accepted when load && ready at a rising edge.
- ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit; 0 when x_valid=0.
- x_valid  output  1  x carries a frame bit this cycle.
- last  output  1  x is the final bit of the frame (parity bit, or data bit 0 when PARITY_EN=0).
- busy  output  1  a frame is in progress (x_valid=1).

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; shift register, bit counter and parity accumulator cleared.
  - Outputs: ready=1, x=0, x_valid=0, last=0, busy=0.
  - A frame in progress is dropped with no partial completion.
  - After release, the first edge behaves as IDLE.
- States: IDLE, SHIFT, PAR. PAR is unreachable when PARITY_EN=0.
- IDLE:
  - ready=1, x_valid=0.
  - On load accepted: sh <= din, cnt <= 0, acc <= ODD, then go to SHIFT.
- SHIFT:
  - x = sh[WIDTH-1], x_valid=1, busy=1.
  - Each edge: sh shifts left by one, acc ^= x, cnt++.
  - When cnt==WIDTH-1 the frame leaves SHIFT: to PAR if PARITY_EN, else the frame ends.
- PAR:
  - x = acc, the running XOR of all data bits, inverted when ODD=1.
  - x_valid=1, last=1, one cycle only.
- last:
  - Asserted on the final frame bit only: SHIFT with cnt==WIDTH-1 when PARITY_EN=0, otherwise PAR.
- ready:
  - ready = (state==IDLE) || last, giving zero-gap back-to-back frames.
  - load accepted during last: the next edge starts the new frame in SHIFT with the new word and a fresh acc. No IDLE cycle and no x_valid gap.
  - If last occurs without load: go to IDLE.
- load while ready=0: ignored; din is not captured and the frame in progress is unaffected.
- Latency:
  - load accepted at edge k: first data bit on x after edge k.
  - Frame length is WIDTH+PARITY_EN cycles; last falls after edge k+WIDTH-1+PARITY_EN.
- All outputs are registered or decoded from registered state only; there is no combinational path from din or load to any output.
- cnt width is $clog2(WIDTH). It never wraps within a frame because it reloads to 0 on every accepted load.

Decomposition:
- Shared package (serial_pkg): state enum {IDLE, SHIFT, PAR} and parity-mode constants PAR_EVEN=0, PAR_ODD=1. The downstream parity detector uses the same package.
- One natural sub-module: tx_bit_counter, a loadable up-counter with a terminal-count flag at WIDTH-1. It is reusable by the receive-side deserializer.
- The shift register and parity accumulator stay inline in serial_word_tx.

Test Plan:
- WIDTH=8, even parity, load din=8'hB5 once:
  - x over 9 cycles = 1,0,1,1,0,1,0,1, then parity 1.
  - x_valid high for 9 cycles; last only on the 9th; ready low cycles 1-8.
- ODD=1, din=8'h00: x = eight 0s then parity 1. Even mode with the same word gives parity 0.
- Back-to-back: hold load=1 with din=8'hFF, then 8'h81.
  - 18 consecutive x_valid cycles with no gap.
  - Frame 2 = 1,0,0,0,0,0,0,1 with parity 0; last pulses at cycles 9 and 18.
- load pulsed with din=8'h3C during cycle 4 of an 8'hB5 frame: ignored; the B5 frame completes unchanged and ready returns to 1.
- Assert rst during cycle 5 of a frame, release 2 cycles later:
  - x=0, x_valid=0, ready=1 immediately, asynchronously.
  - A new load of 8'hA0 then sends 1,0,1,0,0,0,0,0 and parity 0.
- PARITY_EN=0, WIDTH=4, din=4'b1001: x = 1,0,0,1 with last on the 4th bit, and ready=1 in that same cycle.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Brief    : Shared state encoding and parity-mode constants for the serial
//            word transmitter and its downstream parity detector.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_word_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx_if
// Brief    : Load handshake and serial frame signals of the word transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_word_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             last;
    logic             busy;

    // The word producer is the master; the transmitter is the slave.
    modport master (
        output din, load,
        input  ready, x, x_valid, last, busy
    );

    modport slave (
        input  din, load,
        output ready, x, x_valid, last, busy
    );
endinterface : serial_word_tx_if
`default_nettype wire

// File: rtl/tx_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : tx_bit_counter
// Brief    : Clearable bit counter with a terminal-count flag at WIDTH-1.
// Revision : 1.0 - initial release
// ============================================================================
module tx_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_tc
);
    localparam logic [CNT_W-1:0] c_TC = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    // Holding at terminal count keeps the counter from wrapping mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_TC)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == c_TC);

endmodule : tx_bit_counter
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx
// Brief    : Parallel-to-serial MSB-first frame transmitter with optional
//            trailing parity bit and zero-gap back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter bit ODD       = PAR_EVEN
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_word_tx_if.slave  bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic             r_acc;

    logic w_tc;
    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_shift;

    assign w_shift  = (r_state == SHIFT);
    assign w_last   = (w_shift && w_tc && !PARITY_EN) || (r_state == PAR);
    assign w_ready  = (r_state == IDLE) || w_last;
    assign w_accept = bus.load && w_ready;

    tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_inc (w_shift),
        .o_tc  (w_tc)
    );

    // An accepted load always restarts the frame, even out of the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_acc   <= 1'b0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_sh    <= bus.din;
            r_acc   <= ODD;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                    r_acc <= r_acc ^ r_sh[WIDTH-1];
                    if (w_tc) begin
                        r_state <= PARITY_EN ? PAR : IDLE;
                    end
                end
                PAR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.x_valid = (r_state != IDLE);
    assign bus.busy    = (r_state != IDLE);
    assign bus.last    = w_last;
    assign bus.x       = w_shift ? r_sh[WIDTH-1] :
                         (r_state == PAR) ? r_acc : 1'b0;

endmodule : serial_word_tx
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_tx
// Brief    : Directed self-checking bench: even/odd/no-parity instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_tx;
    import serial_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_word_tx_if #(.WIDTH(8)) a ();
    serial_word_tx_if #(.WIDTH(8)) b ();
    serial_word_tx_if #(.WIDTH(4)) c ();

    serial_word_tx #(.WIDTH(8), .PARITY_EN(1'b1), .ODD(PAR_EVEN)) u_even (
        .clk (clk), .rst (rst), .bus (a));
    serial_word_tx #(.WIDTH(8), .PARITY_EN(1'b1), .ODD(PAR_ODD)) u_odd (
        .clk (clk), .rst (rst), .bus (b));
    serial_word_tx #(.WIDTH(4), .PARITY_EN(1'b0), .ODD(PAR_EVEN)) u_nopar (
        .clk (clk), .rst (rst), .bus (c));

    // {x, x_valid, last, ready, busy}
    logic [4:0] w_obs_a, w_obs_b, w_obs_c;
    assign w_obs_a = {a.x, a.x_valid, a.last, a.ready, a.busy};
    assign w_obs_b = {b.x, b.x_valid, b.last, b.ready, b.busy};
    assign w_obs_c = {c.x, c.x_valid, c.last, c.ready, c.busy};

    localparam logic [4:0] c_IDLE = 5'b00010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL reset_even: got %b want %b", w_obs_a, c_IDLE);
        end
        n_checks++;
        if (w_obs_b !== c_IDLE) begin
            n_fail++; $display("FAIL reset_odd: got %b want %b", w_obs_b, c_IDLE);
        end
        n_checks++;
        if (w_obs_c !== c_IDLE) begin
            n_fail++; $display("FAIL reset_nopar: got %b want %b", w_obs_c, c_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_even_frame();
        logic [8:0] bits;
        logic [4:0] exp;
        bits = {8'hB5, 1'b1};
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL b5_pre_idle: got %b want %b", w_obs_a, c_IDLE);
        end
        a.din = 8'hB5; a.load = 1'b1;
        @(negedge clk);
        a.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp = {bits[8-i], 1'b1, (i == 8), (i == 8), 1'b1};
            n_checks++;
            if (w_obs_a !== exp) begin
                n_fail++; $display("FAIL b5_cycle%0d: got %b want %b", i + 1, w_obs_a, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL b5_post_idle: got %b want %b", w_obs_a, c_IDLE);
        end
    endtask

    task automatic test_parity_modes();
        logic [4:0] exp_a, exp_b;
        a.din = 8'h00; a.load = 1'b1;
        b.din = 8'h00; b.load = 1'b1;
        @(negedge clk);
        a.load = 1'b0; b.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_a = {1'b0,            1'b1, (i == 8), (i == 8), 1'b1};
            exp_b = {(i == 8) ? 1'b1 : 1'b0, 1'b1, (i == 8), (i == 8), 1'b1};
            n_checks++;
            if (w_obs_a !== exp_a) begin
                n_fail++; $display("FAIL even00_cycle%0d: got %b want %b", i + 1, w_obs_a, exp_a);
            end
            n_checks++;
            if (w_obs_b !== exp_b) begin
                n_fail++; $display("FAIL odd00_cycle%0d: got %b want %b", i + 1, w_obs_b, exp_b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] bits;
        logic [4:0]  exp;
        bits = {8'hFF, 1'b0, 8'h81, 1'b0};
        a.din = 8'hFF; a.load = 1'b1;
        @(negedge clk);
        a.din = 8'h81;
        for (int i = 0; i < 18; i++) begin
            exp = {bits[17-i], 1'b1, (i == 8 || i == 17), (i == 8 || i == 17), 1'b1};
            n_checks++;
            if (w_obs_a !== exp) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %b want %b", i + 1, w_obs_a, exp);
            end
            if (i == 9) a.load = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL b2b_post_idle: got %b want %b", w_obs_a, c_IDLE);
        end
    endtask

    task automatic test_ignored_load();
        logic [8:0] bits;
        logic [4:0] exp;
        bits = {8'hB5, 1'b1};
        a.din = 8'hB5; a.load = 1'b1;
        @(negedge clk);
        a.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp = {bits[8-i], 1'b1, (i == 8), (i == 8), 1'b1};
            n_checks++;
            if (w_obs_a !== exp) begin
                n_fail++; $display("FAIL ign_cycle%0d: got %b want %b", i + 1, w_obs_a, exp);
            end
            if (i == 3) begin a.din = 8'h3C; a.load = 1'b1; end
            if (i == 4) a.load = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL ign_post_idle: got %b want %b", w_obs_a, c_IDLE);
        end
    endtask

    task automatic test_midframe_reset();
        logic [8:0] bits;
        logic [4:0] exp;
        a.din = 8'hB5; a.load = 1'b1;
        @(negedge clk);
        a.load = 1'b0;
        repeat (4) @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (w_obs_a !== exp) begin
            n_fail++; $display("FAIL rst_cycle5_pre: got %b want %b", w_obs_a, exp);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (w_obs_a !== c_IDLE) begin
            n_fail++; $display("FAIL rst_async: got %b want %b", w_obs_a, c_IDLE);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bits = {8'hA0, 1'b0};
        a.din = 8'hA0; a.load = 1'b1;
        @(negedge clk);
        a.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp = {bits[8-i], 1'b1, (i == 8), (i == 8), 1'b1};
            n_checks++;
            if (w_obs_a !== exp) begin
                n_fail++; $display("FAIL a0_cycle%0d: got %b want %b", i + 1, w_obs_a, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_parity();
        logic [3:0] bits;
        logic [4:0] exp;
        bits = 4'b1001;
        c.din = 4'b1001; c.load = 1'b1;
        @(negedge clk);
        c.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {bits[3-i], 1'b1, (i == 3), (i == 3), 1'b1};
            n_checks++;
            if (w_obs_c !== exp) begin
                n_fail++; $display("FAIL nopar_cycle%0d: got %b want %b", i + 1, w_obs_c, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if (w_obs_c !== c_IDLE) begin
            n_fail++; $display("FAIL nopar_post_idle: got %b want %b", w_obs_c, c_IDLE);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        a.din = '0; a.load = 1'b0;
        b.din = '0; b.load = 1'b0;
        c.din = '0; c.load = 1'b0;
        test_reset();
        test_even_frame();
        test_parity_modes();
        test_back_to_back();
        test_ignored_load();
        test_midframe_reset();
        test_no_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_word_tx
`default_nettype wire
